piso_tx8: RTL
=============

// Module: piso_tx8
// PURPOSE
//   Downstream stage of the 8-bit register: takes the register's parallel q byte and
//   transmits it as an asynchronous serial frame on txd.
//   Frame order: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//   Fixed bit period in clock cycles. Valid/ready-style load handshake so the register
//   stage knows when a new byte may be presented.
// PARAMETERS
//   DATA_W        8   data bits per frame; fixed at 8, other values unsupported
//   CLKS_PER_BIT  4   clk cycles per serial bit; legal range >= 2
// PORTS
//   clk    input   1       system clock; all state updates on posedge
//   rst    input   1       reset, asynchronous, active-high
//   d      input   DATA_W  parallel byte, normally driven by reg8 q
//   load   input   1       request to transmit d; sampled only when ready=1
//   ready  output  1       1 = idle, will accept load this cycle
//   busy   output  1       1 = frame in progress (START/DATA/STOP)
//   txd    output  1       serial line; idles high
//   done   output  1       one-cycle pulse on the final cycle of the stop bit
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, txd=1, ready=1, busy=0, done=0,
//     shift reg=0, bit counter=0, baud counter=0. Takes effect immediately, not at
//     the next edge.
//   States and transitions:
//     IDLE  --load&ready-->  START
//     START --baud wrap-->   DATA
//     DATA  --8th wrap-->    STOP
//     STOP  --baud wrap-->   IDLE
//   Accept:
//     - At the posedge where load=1 and ready=1, d is captured into the shift reg.
//     - State goes to START and the baud counter is cleared.
//     - d may change freely after that edge with no effect on the frame.
//   txd is registered. txd=0 from the cycle after accept; latency from load to
//   start bit = 1 cycle.
//   Bit timing:
//     - Baud counter counts 0..CLKS_PER_BIT-1. Each state/bit lasts exactly
//       CLKS_PER_BIT cycles.
//     - Full frame = 10*CLKS_PER_BIT cycles, i.e. 40 at the default.
//   DATA phase:
//     - txd = shift reg bit 0.
//     - On each baud wrap the shift reg shifts right by 1 and the 3-bit bit counter
//       increments.
//     - After bit 7 (counter=7) wraps, state goes to STOP.
//   STOP phase:
//     - txd=1.
//     - done=1 only in the last cycle of STOP, where baud counter = CLKS_PER_BIT-1.
//     - Next cycle: IDLE, ready=1.
//   ready = (state==IDLE); busy = ~ready.
//   load while busy is ignored entirely: no queueing, no corruption of the current
//   frame.
//   Back-to-back: if load is held high, the next frame is accepted in the first IDLE
//   cycle, so frames are separated by exactly 1 idle-high cycle.
//   Reset mid-frame: frame aborted, txd returns to 1 asynchronously, done does not
//   pulse. After release, only a new load starts a frame.
//   Baud counter width = $clog2(CLKS_PER_BIT). Counter wrap is by compare, not by
//   overflow, so non-power-of-2 values work.
// TESTING  (clk period 20 ns, CLKS_PER_BIT=4)
//   1. Hold rst=1 for 25 ns -> txd=1, ready=1, busy=0, done=0 throughout.
//   2. d=8'b00000001, load pulse 1 cycle -> txd sequence per 4-cycle bit:
//      0 | 1,0,0,0,0,0,0,0 | 1; done high for 1 cycle at cycle 40 after accept.
//   3. d=8'b10011001 accepted, then d changed to 8'hFF mid-frame -> serial data
//      still 1,0,0,1,1,0,0,1 (LSB first).
//   4. load held high while busy, with d=8'h02 -> ignored until done. Next frame
//      starts after exactly 1 idle cycle and carries the d present at that accept
//      edge.
//   5. Assert rst asynchronously (mid-cycle) during DATA bit 3 -> txd=1 and ready=1
//      immediately, no done pulse. A new load after release sends a full, correct
//      frame.
//   6. Self-checking bench: for all 256 d values, sample txd at bit centres,
//      reassemble the byte and compare with d; report any mismatch and the total
//      error count.

Source files
------------

// File: rtl/piso_tx8_if.sv
// Load handshake and serial output bundle between the byte register and the serializer.
interface piso_tx8_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] d;
  logic              load;
  logic              ready;
  logic              busy;
  logic              txd;
  logic              done;

  modport master (output d, load, input ready, busy, txd, done);
  modport slave  (input d, load, output ready, busy, txd, done);
endinterface

// File: rtl/piso_tx8.sv
// Parallel-in serial-out transmitter: start bit, 8 data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks. All outputs are registered.
module piso_tx8 #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx8_if.slave  bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BPRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [2:0]        bitcnt;
  logic [BW-1:0]     bcnt;
  logic              wrap;

  // Compare-based wrap so non-power-of-2 bit periods work.
  assign wrap = (bcnt == BLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bitcnt    <= '0;
      bcnt      <= '0;
      bus.txd   <= 1'b1;
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // ready is high exactly in IDLE, so load alone completes the handshake
          if (bus.load) begin
            sr        <= bus.d;
            bcnt      <= '0;
            bitcnt    <= '0;
            state     <= START;
            bus.txd   <= 1'b0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            bcnt    <= '0;
            state   <= DATA;
            bus.txd <= sr[0];
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            bcnt   <= '0;
            sr     <= sr >> 1;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state   <= STOP;
              bus.txd <= 1'b1;
            end else begin
              bus.txd <= sr[1];
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            bcnt      <= '0;
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end else begin
            bcnt <= bcnt + 1'b1;
            // registered so the pulse lands on the final stop-bit cycle
            if (bcnt == BPRE) bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
